uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Oversamples the asynchronous serial line with the system clock and delivers each received byte with a completion strobe.
- Flags a framing error (stop bit = 0) through a distinct FSM state.
- Sits between the board RX pin and the byte-level consumer logic.

Parameters:
- CLK_PER_BIT, 5208, system clock cycles per bit (50 MHz / 9600 baud). Must be ≥ 4.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idle high; asynchronous to clk.
- data_out  output  8  last received byte.
- rx_done  output  1  one-clock strobe at the end of every frame, good or framing-error.

Behaviour:
- Reset (async, active-high):
  - state = IDLE, counters = 0, data_out = 8'h00, rx_done = 0.
  - Synchronizer flops preset to 1.
- rx passes through a 2-flop synchronizer. All sampling below uses the synchronized value (2-cycle input latency).
- State register is 3 bits, named state, with fixed encoding:
  - IDLE=0, START=1, DATA=2, STOP=3, DONE=4, ERROR=5.
  - The bench probes this encoding hierarchically; it must not change.
- IDLE: clock counter = 0, bit index = 0. Synchronized rx == 0 → START.
- START:
  - Count to CLK_PER_BIT/2 − 1, i.e. the middle of the start bit.
  - rx still 0 → reset counter, go to DATA.
  - rx == 1 → glitch; return to IDLE with no rx_done.
- DATA:
  - Count CLK_PER_BIT − 1 cycles, then sample rx into shift register bit [index], LSB first.
  - After bit 7 is sampled → STOP; otherwise increment index and stay.
- STOP:
  - Count CLK_PER_BIT − 1 cycles, then sample rx at the middle of the stop bit.
  - rx == 1 → DONE; rx == 0 → ERROR.
  - data_out is loaded with the assembled byte on this same transition, for both DONE and ERROR.
- DONE (one clock only):
  - rx_done = 1, state reads 4.
  - Next clock → IDLE, rx_done = 0.
- ERROR:
  - rx_done = 1 on the first clock only, state reads 5.
  - Stays in ERROR while rx == 0, so a low stop bit or break is never taken as a new start bit.
  - First clock with rx == 1 → IDLE.
- rx_done is registered and asserted in the same cycle the state register first shows DONE or ERROR. Both values are therefore stable together when a waiter sees rx_done rise.
- data_out holds its value until the next frame completes. It is not cleared on IDLE.
- Back-to-back frames:
  - DONE is reached half a bit before the stop bit ends.
  - IDLE then waits for the next falling edge. A frame starting right after the stop bit is received correctly.
- Counter width: $clog2(CLK_PER_BIT) bits. Counters wrap to 0 on each bit boundary; no overflow is possible.
- Reset mid-frame aborts immediately to IDLE with the reset values; the partial byte is discarded.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (IDLE..ERROR, 3 bits);
  - default CLK_PER_BIT = 5208;
  - DATA_BITS = 8.
- One natural sub-module, uart_rx_sync: 2-flop synchronizer, async-reset to 1.
- Counter and FSM stay in uart_rx.

Test Plan:
- Reset asserted 2 clocks, rx = 1, then idle 2 bit times → data_out = 8'h00, rx_done = 0, state = 0.
- Send bytes 0x00..0xFF, each with a good stop bit and 2 idle bit times between frames → each rx_done shows data_out == sent byte and state == 4; 256/256 correct.
- Send 0x00..0xFF with stop bit = 0, then raise rx → each rx_done shows data_out == sent byte and state == 5; FSM returns to IDLE only after rx = 1; no spurious frame; 256/256.
- 0x55 then 0xA3 with no idle gap → two rx_done pulses, data_out 8'h55 then 8'hA3, state 4 both times.
- rx low pulse of CLK_PER_BIT/4 cycles → no rx_done; state returns to 0; data_out unchanged.
- Assert reset during bit 4 of 0xF0 → state = 0, data_out = 8'h00, rx_done = 0 at once; the next clean frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receiver: state encoding and frame constants.
package uart_pkg;

    // Encoding is observed externally and must stay fixed.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } rx_state_e;

    localparam int unsigned DEFAULT_CLK_PER_BIT = 5208;
    localparam int unsigned DATA_BITS           = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled mid-bit sampling, byte strobe on every frame end,
// framing errors parked in ERROR until the line returns high.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_done
);

    localparam int unsigned CW = $clog2(CLK_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_END  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    rx_state_e          state, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         data_q, data_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    data_d  = shift_q;
                    done_d  = 1'b1;
                    state_d = rx_s ? DONE : ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERROR: begin
                // A low line here is a bad stop bit or break, never a new start bit.
                if (rx_s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign data_out = data_q;
    assign rx_done  = done_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus queues expected frames, a negedge monitor checks each strobe.
module tb_uart_rx;

    localparam int unsigned CPB = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_done;
    logic [2:0] st_probe;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] st;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    uart_rx #(.CLK_PER_BIT(CPB)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .data_out (data_out),
        .rx_done  (rx_done)
    );

    assign st_probe = dut.state;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_rx_done: got strobe data %h state %0d expected no strobe (t=%0t)",
                         data_out, st_probe, $time);
            end else begin
                e = sb.pop_front();
                check("frame_data", data_out, e.data);
                check("frame_state", {5'b0, st_probe}, {5'b0, e.st});
            end
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_bit);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle_bits(2);
        check("reset_data", data_out, 8'h00);
        check("reset_done", {7'b0, rx_done}, 8'h00);
        check("reset_state", {5'b0, st_probe}, 8'h00);

        for (int b = 0; b < 256; b++) begin
            sb.push_back('{data: 8'(b), st: 3'd4});
            send_frame(8'(b), 1'b1);
            idle_bits(2);
        end

        for (int b = 0; b < 256; b++) begin
            sb.push_back('{data: 8'(b), st: 3'd5});
            send_frame(8'(b), 1'b0);
            send_bit(1'b0);
            check("error_hold", {5'b0, st_probe}, 8'h05);
            idle_bits(2);
            check("error_exit", {5'b0, st_probe}, 8'h00);
        end

        sb.push_back('{data: 8'h55, st: 3'd4});
        sb.push_back('{data: 8'hA3, st: 3'd4});
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        idle_bits(2);

        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        idle_bits(2);
        check("glitch_state", {5'b0, st_probe}, 8'h00);
        check("glitch_data", data_out, 8'hA3);

        // Abort 0xF0 halfway through bit 4.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_state", {5'b0, st_probe}, 8'h00);
        check("midreset_data", data_out, 8'h00);
        check("midreset_done", {7'b0, rx_done}, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle_bits(2);
        check("postreset_state", {5'b0, st_probe}, 8'h00);

        sb.push_back('{data: 8'h3C, st: 3'd4});
        send_frame(8'h3C, 1'b1);
        idle_bits(2);

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL missing_frames: got %0d frames still pending expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
